// File: rtl/sram_req_arbiter.sv
// Merges the fetch and data request streams onto one sram-like port, with the data
// side taking priority. A small in-order ID FIFO steers each response back to its source.
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic          lock_q, lock_d;
  logic          lock_src_q, lock_src_d;
  logic          src_fifo_q [DEPTH];
  logic          src_fifo_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic sel;
  logic lock_hold;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_src;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    head_src  = src_fifo_q[rd_ptr_q];
    // A lock only holds while its owner still requests; a cancel releases it at once.
    lock_hold = lock_q & ((lock_src_q == SRC_DATA) ? data_req : inst_req);
    if (lock_hold) begin
      sel = lock_src_q;
    end else if (data_req) begin
      sel = SRC_DATA;
    end else begin
      sel = SRC_INST;
    end
    mem_req = resetn & (data_req | inst_req) & ~full;
  end

  always_comb begin
    if (sel == SRC_DATA) begin
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = 1'b0;
      mem_wstrb = 4'h0;
      mem_addr  = inst_addr;
      mem_wdata = 32'h0;
    end
    inst_addr_ok = mem_addr_ok & mem_req & (sel == SRC_INST);
    data_addr_ok = mem_addr_ok & mem_req & (sel == SRC_DATA);
    // A response with nothing outstanding is a protocol error and is dropped.
    pop          = resetn & mem_data_ok & ~empty;
    push         = mem_req & mem_addr_ok;
    inst_data_ok = pop & (head_src == SRC_INST);
    data_data_ok = pop & (head_src == SRC_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  always_comb begin
    lock_d     = 1'b0;
    lock_src_d = lock_src_q;
    if (mem_req && !mem_addr_ok) begin
      lock_d     = 1'b1;
      lock_src_d = sel;
    end
    src_fifo_d = src_fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      src_fifo_d[wr_ptr_q] = sel;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INST;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src_fifo_q[i] <= SRC_INST;
      end
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        src_fifo_q[i] <= src_fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: expected requests and responses are queued
// as stimulus is issued and two monitors compare them against what the DUT presents.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // {src, wr, wstrb, addr, wdata}
  logic [69:0] req_exp_q[$];
  // {src, rdata}
  logic [32:0] resp_exp_q[$];

  sram_req_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  task automatic exp_inst_req(input logic [31:0] addr);
    req_exp_q.push_back({1'b0, 1'b0, 4'h0, addr, 32'h0});
  endtask

  task automatic exp_data_req(input logic wr, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_exp_q.push_back({1'b1, wr, strb, addr, wdata});
  endtask

  task automatic exp_resp(input logic src, input logic [31:0] rdata);
    resp_exp_q.push_back({src, rdata});
  endtask

  task automatic respond(input logic [31:0] rdata);
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    tick();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  // request-side monitor
  always @(negedge clk) begin
    if ((mem_req && mem_addr_ok) || inst_addr_ok || data_addr_ok) begin
      logic [69:0] exp;
      checks++;
      if (req_exp_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: addr %0h accepted, required no acceptance", mem_addr);
      end else begin
        exp = req_exp_q.pop_front();
        if ({data_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== exp ||
            inst_addr_ok !== ~data_addr_ok || !mem_req || !mem_addr_ok) begin
          errors++;
          $display("FAIL req_accept: got %0h (inst_ok %0b) expected %0h",
                   {data_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata}, inst_addr_ok, exp);
        end
      end
    end
  end

  // response-side monitor
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      logic [32:0] exp;
      logic [31:0] rd;
      checks++;
      rd = data_data_ok ? data_rdata : inst_rdata;
      if (resp_exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: inst_ok %0b data_ok %0b, required none",
                 inst_data_ok, data_data_ok);
      end else begin
        exp = resp_exp_q.pop_front();
        if (inst_data_ok === data_data_ok || data_data_ok !== exp[32] || rd !== exp[31:0]) begin
          errors++;
          $display("FAIL resp_route: got src %0b data %0h expected src %0b data %0h",
                   data_data_ok, rd, exp[32], exp[31:0]);
        end
      end
    end
  end

  initial begin
    drive_idle();
    resetn = 1'b0;
    // reset: handshakes held low even with every input asserted
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("reset_handshakes", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 70'h0);
    tick();
    tick();
    drive_idle();
    resetn = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_mem_req", mem_req, 70'h0);
    tick();

    // read contention: data wins, inst next cycle, responses in order
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
    data_req = 1'b1; data_addr = 32'h0000_1000;
    mem_addr_ok = 1'b1;
    exp_data_req(1'b0, 4'h0, 32'h0000_1000, 32'h0);
    exp_resp(1'b1, 32'hAAAA_0000);
    @(negedge clk);
    chk("contend_addr_ok", {inst_addr_ok, data_addr_ok}, 70'h1);
    tick();
    data_req = 1'b0;
    exp_inst_req(32'h1FC0_0000);
    exp_resp(1'b0, 32'hBBBB_0000);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    respond(32'hAAAA_0000);
    respond(32'hBBBB_0000);
    tick();

    // lock: inst stalled three cycles, data arrives in cycle 2 and must wait
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    @(negedge clk);
    chk("lock_c1_addr", {mem_req, mem_addr}, {38'h0, 1'b1, 32'hBFC0_0100} & 70'h1_FFFF_FFFF);
    tick();
    data_req = 1'b1; data_addr = 32'h0000_2000; data_wstrb = 4'h0;
    @(negedge clk);
    chk("lock_c2_addr", mem_addr, 32'hBFC0_0100);
    chk("lock_c2_wr", {mem_wr, mem_wstrb}, 70'h0);
    tick();
    @(negedge clk);
    chk("lock_c3_addr", mem_addr, 32'hBFC0_0100);
    tick();
    mem_addr_ok = 1'b1;
    exp_inst_req(32'hBFC0_0100);
    exp_resp(1'b0, 32'h1111_0000);
    tick();
    inst_req = 1'b0;
    exp_data_req(1'b0, 4'h0, 32'h0000_2000, 32'h0);
    exp_resp(1'b1, 32'h2222_0000);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    respond(32'h1111_0000);
    respond(32'h2222_0000);

    // cancel: locked inst drops its request, data takes the port that cycle
    inst_req = 1'b1; inst_addr = 32'h0000_0400;
    tick();
    inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_5000;
    @(negedge clk);
    chk("cancel_switch", {mem_req, mem_addr}, {37'h0, 1'b1, 32'h0000_5000});
    tick();
    data_req = 1'b0;
    @(negedge clk);
    chk("cancel_idle", mem_req, 70'h0);
    tick();

    // full: four reads outstanding mask the fifth, pop does not refill same cycle
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inst_addr = 32'h0000_0100 + 32'(k * 4);
      exp_inst_req(inst_addr);
      exp_resp(1'b0, 32'hC000_0000 + 32'(k));
      tick();
    end
    inst_addr = 32'h0000_0110;
    @(negedge clk);
    chk("full_masked", {mem_req, inst_addr_ok}, 70'h0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hC000_0000;
    @(negedge clk);
    chk("full_no_refill", mem_req, 70'h0);
    tick();
    mem_data_ok = 1'b0;
    exp_inst_req(32'h0000_0110);
    exp_resp(1'b0, 32'hC000_0004);
    @(negedge clk);
    chk("full_refill_next", mem_req, 70'h1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    for (int k = 1; k < 5; k++) begin
      respond(32'hC000_0000 + 32'(k));
    end

    // write: strobes and data pass through, completion goes to data side
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3;
    data_addr = 32'h0000_3000; data_wdata = 32'h1234_5678; mem_addr_ok = 1'b1;
    exp_data_req(1'b1, 4'h3, 32'h0000_3000, 32'h1234_5678);
    exp_resp(1'b1, 32'h0000_0000);
    @(negedge clk);
    chk("write_strb_data", {mem_wr, mem_wstrb, mem_wdata}, {33'h0, 1'b1, 4'h3, 32'h1234_5678});
    tick();
    drive_idle();
    tick();
    tick();
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("write_done_route", {inst_data_ok, data_data_ok}, 70'h1);
    tick();
    mem_data_ok = 1'b0;

    // pointer wrap: ten alternating requests, each answered two cycles later
    for (int k = 0; k < 12; k++) begin
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0; mem_rdata = 32'h0;
      if (k < 10) begin
        mem_addr_ok = 1'b1;
        if (k % 2 == 0) begin
          inst_req  = 1'b1;
          inst_addr = 32'h0000_8000 + 32'(k * 4);
          exp_inst_req(inst_addr);
          exp_resp(1'b0, 32'hD000_0000 + 32'(k));
        end else begin
          data_req  = 1'b1;
          data_addr = 32'h0000_9000 + 32'(k * 4);
          exp_data_req(1'b0, 4'h0, data_addr, 32'h0);
          exp_resp(1'b1, 32'hD000_0000 + 32'(k));
        end
      end
      if (k >= 2) begin
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hD000_0000 + 32'(k - 2);
      end
      tick();
    end
    drive_idle();
    // with nothing outstanding a response must be ignored
    mem_data_ok = 1'b1; mem_rdata = 32'hEEEE_0000;
    @(negedge clk);
    chk("empty_ignored", {inst_data_ok, data_data_ok}, 70'h0);
    tick();
    mem_data_ok = 1'b0;

    // reset mid-flight: two requests outstanding are dropped
    inst_req = 1'b1; inst_addr = 32'h0000_A000; mem_addr_ok = 1'b1;
    exp_inst_req(32'h0000_A000);
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_B000;
    exp_data_req(1'b0, 4'h0, 32'h0000_B000, 32'h0);
    tick();
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("midreset_handshakes",
        {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 70'h0);
    tick();
    drive_idle();
    resetn = 1'b1;
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stray_after_reset", {inst_data_ok, data_data_ok}, 70'h0);
    tick();
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_C000; mem_addr_ok = 1'b1;
    exp_inst_req(32'h0000_C000);
    exp_resp(1'b0, 32'h3333_0000);
    tick();
    drive_idle();
    respond(32'h3333_0000);
    tick();
    tick();

    // final report
    chk("req_queue_drained", 70'(req_exp_q.size()), 70'h0);
    chk("resp_queue_drained", 70'(resp_exp_q.size()), 70'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Merges the instruction-fetch and data-access request streams from the CPU core into one sram-like memory port, after address translation.
- Data side has priority. Responses return strictly in request order.
- A small ID FIFO records the source of each in-flight request.
- Sits between the core/mmu pair and the single downstream memory/bus bridge.

Parameters:
- DEPTH, 4, maximum number of accepted requests awaiting mem_data_ok; power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- resetn  input  1  synchronous active-low reset
- inst_req  input  1  fetch request valid (read only)
- inst_addr  input  32  physical fetch address
- inst_addr_ok  output  1  fetch request accepted this cycle
- inst_data_ok  output  1  fetch response valid this cycle
- inst_rdata  output  32  fetch response data
- data_req  input  1  data request valid
- data_wr  input  1  1 = write, 0 = read
- data_wstrb  input  4  byte write strobes, ignored on reads
- data_addr  input  32  physical data address
- data_wdata  input  32  write data
- data_addr_ok  output  1  data request accepted this cycle
- data_data_ok  output  1  data response valid (read data, or write completion)
- data_rdata  output  32  data response data
- mem_req  output  1  merged request valid
- mem_wr  output  1  merged write flag
- mem_wstrb  output  4  merged strobes
- mem_addr  output  32  merged address
- mem_wdata  output  32  merged write data
- mem_addr_ok  input  1  memory accepted request
- mem_data_ok  input  1  memory response valid, in order
- mem_rdata  input  32  memory response data

Behaviour:
- Reset: one clock, synchronous, active-low. While resetn=0, every output handshake (mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok) is forced 0.
- Reset clears the FIFO (count=0, rd_ptr=wr_ptr=0) and the grant lock. Responses arriving after reset are not routed. Reset mid-transaction drops all in-flight IDs; the memory side is reset by the same resetn.
- Handshake: a request transfers in a cycle where mem_req & mem_addr_ok. A response transfers in a cycle where mem_data_ok. Writes also produce exactly one data_ok.
- Grant, when unlocked:
  - sel = DATA if data_req, else INST if inst_req.
  - mem_req = (data_req | inst_req) & (count != DEPTH).
- Grant lock:
  - If mem_req=1 and mem_addr_ok=0, register lock=1 and lock_src=sel.
  - While locked, sel=lock_src regardless of the other requester, so the presented request does not change before acceptance.
  - The lock clears on acceptance.
  - If the locked requester drops its req, the lock also clears (core cancel, e.g. on flush). mem_req deasserts that cycle unless the other requester is active.
- Mux:
  - sel=DATA: mem_wr/mem_wstrb/mem_addr/mem_wdata come from the data_* inputs.
  - sel=INST: mem_wr=0, mem_wstrb=0, mem_addr=inst_addr, mem_wdata=0.
- addr_ok routing (combinational):
  - inst_addr_ok = mem_addr_ok & mem_req & sel==INST.
  - data_addr_ok = mem_addr_ok & mem_req & sel==DATA.
- FIFO (1-bit source ID per entry):
  - Push sel on request transfer; pop on mem_data_ok.
  - Responses route to the head entry's source: inst_data_ok or data_data_ok = mem_data_ok & (head==source).
  - inst_rdata = data_rdata = mem_rdata, unconditionally (zero added latency).
- Full: count==DEPTH masks mem_req, even if a pop occurs in the same cycle (no same-cycle refill; timing decision).
- Simultaneous push and pop: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- Empty: mem_data_ok with count==0 is a protocol error. It is ignored: no data_ok asserted, no pop, count stays 0.
- Latency: zero cycles request-to-mem_req and response-to-data_ok (pure combinational paths). State updates take effect on the next edge.

Test Plan:
- Read contention: inst_req and data_req both high, addr 0x1FC00000 and 0x00001000, mem_addr_ok=1 -> data accepted first, inst next cycle. Responses 0xAAAA0000 and 0xBBBB0000 route to data_rdata then inst_rdata.
- Lock: inst_req alone, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays inst_addr until acceptance; data served afterwards.
- Full: DEPTH=4, accept 4 reads with no mem_data_ok -> mem_req=0 on the 5th request. One mem_data_ok -> mem_req=1 the following cycle, not the same cycle.
- Write: data_wr=1, wstrb=0x3, wdata=0x12345678 -> mem_wstrb=0x3, mem_wdata=0x12345678. A later mem_data_ok gives data_data_ok=1 and inst_data_ok=0.
- Pointer wrap: 10 alternating inst/data requests, each answered 2 cycles later -> every response goes to the correct side, count returns to 0.
- Reset mid-flight: 2 requests outstanding, resetn=0 for 1 cycle -> all handshakes 0 during reset. A stray mem_data_ok afterwards produces no data_ok.
